sma_sixteen_subtractor_pipe: RTL
================================

# sma_sixteen_subtractor_pipe

Pipelined sign-magnitude subtractor that computes a − b on DATA_WIDTH-bit sign-magnitude operands and returns a DATA_WIDTH+1-bit sign-magnitude difference. It is the inverse of the sign-magnitude adder in the datapath. Operands enter on a valid/ready stream and results leave on a second valid/ready stream. A two-stage pipeline sustains one result per cycle and supports full backpressure.

## Interface
- DATA_WIDTH, 8, operand width; MSB is the sign (1 = negative), the low DATA_WIDTH-1 bits are the magnitude
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair a/b is present
- in_ready  out  1  block accepts the pair this cycle
- a  in  DATA_WIDTH  minuend, sign-magnitude
- b  in  DATA_WIDTH  subtrahend, sign-magnitude
- out_valid  out  1  diff/out_zero are valid
- out_ready  in  1  downstream consumes the result this cycle
- diff  out  DATA_WIDTH+1  result {sign, DATA_WIDTH-bit magnitude}
- out_zero  out  1  result magnitude is 0

## Operation
- An input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready.
- Arithmetic:
  - Let as = a[MSB], am = a magnitude, bs' = ~b[MSB], bm = b magnitude.
  - If as == bs': mag = am + bm, sign = as.
  - Else if am >= bm: mag = am − bm, sign = as.
  - Else: mag = bm − am, sign = bs'.
- mag is DATA_WIDTH bits wide, zero-extended, and never overflows. The maximum is 2·(2^(DATA_WIDTH-1)−1).
- Zero normalization: if mag == 0, the sign is forced to 0 and out_zero = 1. Negative-zero inputs (sign=1, mag=0) are legal and treated as 0.
- Stage 1 (s1) registers:
  - as and bs'
  - both magnitudes
  - operation select: add/sub
  - compare result: am >= bm
- Stage 2 (s2) registers: the final diff and out_zero.
- Each stage holds a valid bit.
- Flow control:
  - s2_load = s1_valid && (!s2_valid || out_ready)
  - in_ready = !s1_valid || !s2_valid || out_ready. This is combinational from out_ready and pipeline state; there is no combinational path from in_valid.
  - A stage holds its contents while it cannot advance.
  - s2_valid clears on an output transfer with no s2_load in the same cycle.
- Simultaneous input and output transfer in the same cycle: both occur, with no bubble and no loss.
- Ordering: results leave in acceptance order. No duplication or drop under any out_ready pattern.

## Timing
- Reset (rst_n low, asynchronous):
  - s1_valid = 0, s2_valid = 0, out_valid = 0
  - diff = 0, out_zero = 0, all stage data = 0
  - in_ready = 1 from the first cycle after reset while out_ready is don't-care, since the pipeline is empty
- Reset asserted mid-stream: in-flight results are discarded; out_valid drops immediately (asynchronously).
- Latency: a pair accepted at edge k has out_valid = 1 after edge k+1, i.e. 2 cycles, when out_ready was high.
- Throughput: 1 result/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, diff and out_zero are held stable. The block buffers at most 2 pairs; in_ready is 0 when both stages are full and out_ready = 0.
- Release: the first cycle out_ready returns to 1, in_ready = 1 in that same cycle.

## Test plan
- a=0x05 (+5), b=0x03 (+3) → diff=9'h002, out_zero=0, out_valid 2 cycles after accept.
- a=0x03, b=0x05 → diff=9'h102 (−2); a=0x64 (+100), b=0xE4 (−100) → diff=9'h0C8 (+200).
- a=0xFF (−127), b=0x7F (+127) → diff=9'h1FE (−254), the largest magnitude; a=0x80 (−0), b=0x00 → diff=9'h000, out_zero=1; a=0x85, b=0x85 → diff=9'h000, out_zero=1 (no −0).
- Stream of 6 back-to-back pairs with out_ready=1 → 6 results on consecutive cycles, in order, in_ready constantly 1.
- Same stream with out_ready=0 for 4 cycles mid-stream → in_ready drops once 2 pairs are held, diff stable during the stall, all 6 results delivered in order with no duplicates.
- Assert rst_n=0 with both stages valid → out_valid=0 and diff=0 immediately. After release, in_ready=1 and the next pair produces a correct result in 2 cycles.

Source files
------------

// File: rtl/sma_sixteen_subtractor_pipe.sv
// Two-stage pipelined sign-magnitude subtractor (a - b) with valid/ready on both sides.
// Stage 1 captures decoded operands and the magnitude compare; stage 2 holds the normalized result.
module sma_sixteen_subtractor_pipe #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH:0]   diff,
    output logic                  out_zero
);

    localparam int MAG_W = DATA_WIDTH - 1;

    logic             s1_valid;
    logic             s1_a_sign;
    logic             s1_b_sign;
    logic [MAG_W-1:0] s1_a_mag;
    logic [MAG_W-1:0] s1_b_mag;
    logic             s1_is_add;
    logic             s1_a_ge_b;

    logic             s2_valid;

    logic             in_fire;
    logic             s2_load;
    logic             out_fire;

    logic             a_sign;
    logic             b_sign_inv;
    logic [MAG_W-1:0] a_mag;
    logic [MAG_W-1:0] b_mag;

    logic [DATA_WIDTH-1:0] res_mag;
    logic                  res_sign;
    logic                  res_zero;

    // Subtraction is addition of b with its sign flipped.
    assign a_sign     = a[DATA_WIDTH-1];
    assign b_sign_inv = ~b[DATA_WIDTH-1];
    assign a_mag      = a[MAG_W-1:0];
    assign b_mag      = b[MAG_W-1:0];

    assign out_fire  = s2_valid && out_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a_sign <= 1'b0;
            s1_b_sign <= 1'b0;
            s1_a_mag  <= '0;
            s1_b_mag  <= '0;
            s1_is_add <= 1'b0;
            s1_a_ge_b <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_a_sign <= a_sign;
                s1_b_sign <= b_sign_inv;
                s1_a_mag  <= a_mag;
                s1_b_mag  <= b_mag;
                s1_is_add <= (a_sign == b_sign_inv);
                s1_a_ge_b <= (a_mag >= b_mag);
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Magnitude is one bit wider than the operand magnitudes, so the sum cannot overflow.
    always_comb begin
        res_mag  = '0;
        res_sign = 1'b0;
        if (s1_is_add) begin
            res_mag  = {1'b0, s1_a_mag} + {1'b0, s1_b_mag};
            res_sign = s1_a_sign;
        end else if (s1_a_ge_b) begin
            res_mag  = {1'b0, s1_a_mag} - {1'b0, s1_b_mag};
            res_sign = s1_a_sign;
        end else begin
            res_mag  = {1'b0, s1_b_mag} - {1'b0, s1_a_mag};
            res_sign = s1_b_sign;
        end
        res_zero = (res_mag == '0);
        if (res_zero) begin
            res_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            diff     <= '0;
            out_zero <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                diff     <= {res_sign, res_mag};
                out_zero <= res_zero;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
        end
    end

endmodule
